// File: rtl/vga_pkg.sv
// Shared VGA geometry constants and the register set type used by the sprite overlay engine.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COL_W    = 10;
  localparam int ROW_W    = 9;
  localparam int RGB_W    = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic             vis;
    logic [COL_W-1:0] x;
    logic [ROW_W-1:0] y;
    rgb_t             rgb;
  } spr_regs_t;

endpackage

// File: rtl/sprite_unit.sv
// One sprite: double-buffered position/colour registers, box test, ROM address and in_box delay
// line aligning the hit flag with the ROM data.
module sprite_unit
  import vga_pkg::*;
#(
  parameter int SPR_W   = 128,
  parameter int SPR_H   = 128,
  parameter int ROM_LAT = 1,
  parameter int AW      = 14
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             frame_start,
  input  logic             wr_sel,
  input  logic [COL_W-1:0] wr_x,
  input  logic [ROW_W-1:0] wr_y,
  input  logic [RGB_W-1:0] wr_rgb,
  input  logic             wr_vis,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [AW-1:0]    rom_addr,
  output logic             in_box_dly,
  output logic [RGB_W-1:0] rgb
);

  spr_regs_t        shadow_q, shadow_d, active_q, active_d, wr_regs;
  logic             in_box_q, in_box_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [ROM_LAT-1:0] dly_q, dly_d;
  logic [COL_W:0]   col_end;
  logic [ROW_W:0]   row_end;
  logic [COL_W-1:0] dx;
  logic [ROW_W-1:0] dy;

  always_comb begin
    wr_regs.vis = wr_vis;
    wr_regs.x   = wr_x;
    wr_regs.y   = wr_y;
    wr_regs.rgb = wr_rgb;
    shadow_d = wr_sel ? wr_regs : shadow_q;
    // Taking shadow_d (not shadow_q) forwards a same-cycle write into the new frame.
    active_d = frame_start ? shadow_d : active_q;

    // One extra bit so a sprite hanging off the right/bottom edge never wraps to 0.
    col_end  = {1'b0, active_q.x} + (COL_W+1)'(SPR_W);
    row_end  = {1'b0, active_q.y} + (ROW_W+1)'(SPR_H);
    in_box_d = active_q.vis &&
               (col >= active_q.x) && ({1'b0, col} < col_end) &&
               (row >= active_q.y) && ({1'b0, row} < row_end);
    dx     = col - active_q.x;
    dy     = row - active_q.y;
    addr_d = in_box_d ? AW'(20'(dy) * 20'(SPR_W) + 20'(dx)) : '0;

    dly_d    = '0;
    dly_d[0] = in_box_q;
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      in_box_q <= 1'b0;
      addr_q   <= '0;
      dly_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      in_box_q <= in_box_d;
      addr_q   <= addr_d;
      dly_q    <= dly_d;
    end
  end

  assign rom_addr   = addr_q;
  assign in_box_dly = dly_q[ROM_LAT-1];
  assign rgb        = active_q.rgb;

endmodule

// File: rtl/vga_sprite_compositor.sv
// N-sprite overlay: per-sprite units, fixed-priority compositor over a background colour and a
// per-frame collision accumulator. Latency col/row -> rgb_out is ROM_LAT+2 cycles.
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter  int N_SPR   = 4,
  parameter  int SPR_W   = 128,
  parameter  int SPR_H   = 128,
  parameter  int ROM_LAT = 1,
  parameter  int DW      = 16,
  localparam int IW      = (N_SPR > 1) ? $clog2(N_SPR) : 1,
  localparam int AW      = $clog2(SPR_W * SPR_H)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               frame_start,
  input  logic               disp_ena,
  input  logic [9:0]         col,
  input  logic [8:0]         row,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [9:0]         wr_x,
  input  logic [8:0]         wr_y,
  input  logic [11:0]        wr_rgb,
  input  logic               wr_vis,
  input  logic [11:0]        bg_rgb,
  output logic [N_SPR*AW-1:0] rom_addr,
  input  logic [N_SPR*DW-1:0] rom_data,
  output logic [11:0]        rgb_out,
  output logic [IW-1:0]      hit_idx,
  output logic               hit_any,
  output logic [N_SPR-1:0]   collision
);

  logic [N_SPR-1:0] in_box, opaque, hits;
  rgb_t             spr_rgb [N_SPR];
  logic [ROM_LAT:0] de_q, de_d;
  logic [N_SPR-1:0] work_q, work_d, coll_q, coll_d;
  rgb_t             rgb_q, rgb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             any_q, any_d, multi;

  for (genvar g = 0; g < N_SPR; g++) begin : g_spr
    sprite_unit #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .ROM_LAT (ROM_LAT),
      .AW      (AW)
    ) u_spr (
      .clk         (clk),
      .arst_n      (arst_n),
      .frame_start (frame_start),
      .wr_sel      (wr_en && (wr_idx == IW'(g))),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_rgb      (wr_rgb),
      .wr_vis      (wr_vis),
      .col         (col),
      .row         (row),
      .rom_addr    (rom_addr[g*AW +: AW]),
      .in_box_dly  (in_box[g]),
      .rgb         (spr_rgb[g])
    );
  end

  always_comb begin
    de_d    = '0;
    de_d[0] = disp_ena;
    for (int unsigned i = 1; i <= ROM_LAT; i++) begin
      de_d[i] = de_q[i-1];
    end

    rgb_d = bg_rgb;
    any_d = 1'b0;
    idx_d = '0;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      opaque[i] = in_box[i] && (rom_data[i*DW +: DW] != '0);
      if (opaque[i] && !any_d) begin
        rgb_d = spr_rgb[i];
        any_d = 1'b1;
        idx_d = IW'(i);
      end
    end
    if (!de_q[ROM_LAT]) begin
      rgb_d = '0;
      any_d = 1'b0;
      idx_d = '0;
    end

    // x & (x-1) is non-zero exactly when two or more sprites are opaque here.
    multi  = |(opaque & (opaque - N_SPR'(1)));
    hits   = (de_q[ROM_LAT] && multi) ? opaque : '0;
    work_d = frame_start ? hits : (work_q | hits);
    coll_d = frame_start ? work_q : coll_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      de_q   <= '0;
      work_q <= '0;
      coll_q <= '0;
      rgb_q  <= '0;
      idx_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      de_q   <= de_d;
      work_q <= work_d;
      coll_q <= coll_d;
      rgb_q  <= rgb_d;
      idx_q  <= idx_d;
      any_q  <= any_d;
    end
  end

  assign rgb_out   = rgb_q;
  assign hit_idx   = idx_q;
  assign hit_any   = any_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with the cycle they are due,
// a negedge monitor pops and compares them.
module tb_vga_sprite_compositor;

  localparam int N_SPR   = 5;
  localparam int SPR_W   = 128;
  localparam int SPR_H   = 128;
  localparam int ROM_LAT = 1;
  localparam int DW      = 16;
  localparam int IW      = 3;
  localparam int AW      = 14;
  localparam int LAT     = ROM_LAT + 2;

  logic clk, arst_n, frame_start, disp_ena, wr_en, wr_vis, hit_any;
  logic [9:0]  col, wr_x;
  logic [8:0]  row, wr_y;
  logic [IW-1:0] wr_idx, hit_idx;
  logic [11:0] wr_rgb, bg_rgb, rgb_out;
  logic [N_SPR*AW-1:0] rom_addr;
  logic [N_SPR*DW-1:0] rom_data;
  logic [N_SPR-1:0]    collision;

  vga_sprite_compositor #(
    .N_SPR(N_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT), .DW(DW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .frame_start(frame_start), .disp_ena(disp_ena),
    .col(col), .row(row), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_rgb(wr_rgb), .wr_vis(wr_vis), .bg_rgb(bg_rgb), .rom_addr(rom_addr),
    .rom_data(rom_data), .rgb_out(rgb_out), .hit_idx(hit_idx), .hit_any(hit_any),
    .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sprite ROM model, one-cycle latency: every word opaque except address 3.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return (a == 14'd3) ? '0 : (DW'(a) + 16'd1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N_SPR; i++) rom_data[i*DW +: DW] <= rom_fn(rom_addr[i*AW +: AW]);
  end

  typedef enum int {K_PIX, K_ADDR, K_COLL, K_ZERO} kind_e;
  typedef struct {
    kind_e         kind;
    int            due;
    string         name;
    logic [11:0]   rgb;
    logic          any;
    logic [IW-1:0] idx;
    int            spr;
    logic [AW-1:0] addr;
    logic [N_SPR-1:0] coll;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input exp_t e);
    logic [AW-1:0] a;
    n_vec++;
    case (e.kind)
      K_PIX: if (rgb_out !== e.rgb || hit_any !== e.any || hit_idx !== e.idx) begin
        n_bad++;
        $display("FAIL %s: got rgb=%h any=%b idx=%0d, want rgb=%h any=%b idx=%0d",
                 e.name, rgb_out, hit_any, hit_idx, e.rgb, e.any, e.idx);
      end
      K_ADDR: begin
        a = rom_addr[e.spr*AW +: AW];
        if (a !== e.addr) begin
          n_bad++;
          $display("FAIL %s: got rom_addr%0d=%0d, want %0d", e.name, e.spr, a, e.addr);
        end
      end
      K_COLL: if (collision !== e.coll) begin
        n_bad++;
        $display("FAIL %s: got collision=%b, want %b", e.name, collision, e.coll);
      end
      default: if (rgb_out !== '0 || hit_any !== 1'b0 || hit_idx !== '0 ||
                   collision !== '0 || rom_addr !== '0) begin
        n_bad++;
        $display("FAIL %s: got rgb=%h any=%b idx=%0d coll=%b addr=%h, want all zero",
                 e.name, rgb_out, hit_any, hit_idx, collision, rom_addr);
      end
    endcase
  endtask

  always @(negedge clk) begin : monitor
    int k;
    k = 0;
    while (k < q.size()) begin
      if (q[k].due == cyc) begin
        check(q[k]);
        q.delete(k);
      end else if (q[k].due < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: not sampled, got cycle %0d, want cycle %0d", q[k].name, cyc, q[k].due);
        q.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic begin_cycle();
    @(negedge clk);
    wr_en = 1'b0;
    frame_start = 1'b0;
    disp_ena = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin_cycle();
  endtask

  task automatic write_spr(input int idx, input int x, input int y, input logic [11:0] c,
                           input logic fs);
    begin_cycle();
    wr_en = 1'b1; wr_idx = IW'(idx); wr_x = 10'(x); wr_y = 9'(y);
    wr_rgb = c; wr_vis = 1'b1; frame_start = fs;
  endtask

  task automatic frame_pulse();
    begin_cycle();
    frame_start = 1'b1;
  endtask

  task automatic drive_px(input int c, input int r, input logic de);
    begin_cycle();
    col = 10'(c); row = 9'(r); disp_ena = de;
  endtask

  task automatic pix(input int c, input int r, input logic de, input logic [11:0] er,
                     input logic ea, input int ei, input string nm);
    exp_t e;
    drive_px(c, r, de);
    e.kind = K_PIX; e.due = cyc + LAT; e.name = nm; e.rgb = er; e.any = ea; e.idx = IW'(ei);
    q.push_back(e);
  endtask

  task automatic exp_addr(input int s, input int a, input string nm);
    exp_t e;
    e.kind = K_ADDR; e.due = cyc + 1; e.name = nm; e.spr = s; e.addr = AW'(a);
    q.push_back(e);
  endtask

  task automatic exp_coll(input logic [N_SPR-1:0] c, input string nm);
    exp_t e;
    e.kind = K_COLL; e.due = cyc + 1; e.name = nm; e.coll = c;
    q.push_back(e);
  endtask

  task automatic exp_zero(input string nm);
    exp_t e;
    e.kind = K_ZERO; e.due = cyc + 1; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    arst_n = 1'b0; frame_start = 1'b0; disp_ena = 1'b0; col = '0; row = '0;
    wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_rgb = '0; wr_vis = 1'b0;
    bg_rgb = 12'h123;

    @(negedge clk);
    exp_zero("reset_state");
    @(negedge clk);
    #1 arst_n = 1'b1;

    // No sprites written: background only.
    pix(0, 0, 1'b1, 12'h123, 1'b0, 0, "t1_bg");
    pix(320, 240, 1'b1, 12'h123, 1'b0, 0, "t1_bg_mid");

    // Single sprite: corners, transparent word, edges, blanking.
    idle(3);
    write_spr(0, 256, 176, 12'h0F0, 1'b0);
    frame_pulse();
    pix(256, 176, 1'b1, 12'h0F0, 1'b1, 0, "t2_topleft");     exp_addr(0, 0, "t2_addr_tl");
    pix(259, 176, 1'b1, 12'h123, 1'b0, 0, "t2_transparent"); exp_addr(0, 3, "t2_addr3");
    pix(383, 303, 1'b1, 12'h0F0, 1'b1, 0, "t2_botright");    exp_addr(0, 16383, "t2_addr_br");
    pix(384, 303, 1'b1, 12'h123, 1'b0, 0, "t2_right_out");   exp_addr(0, 0, "t2_addr_out");
    pix(300, 304, 1'b1, 12'h123, 1'b0, 0, "t2_below");
    pix(300, 200, 1'b0, 12'h000, 1'b0, 0, "t2_blank");

    // Two overlapping opaque sprites: priority and collision.
    idle(3);
    write_spr(1, 300, 200, 12'hF00, 1'b0);
    frame_pulse();                    exp_coll(5'b00000, "t3_coll_before");
    pix(300, 200, 1'b1, 12'h0F0, 1'b1, 0, "t3_overlap");   exp_addr(1, 0, "t3_addr1");
    pix(390, 210, 1'b1, 12'hF00, 1'b1, 1, "t3_spr1_only"); exp_addr(1, 1370, "t3_addr1b");
    idle(3);
    frame_pulse();                    exp_coll(5'b00011, "t3_coll");

    // Mid-frame write stays in shadow until frame_start; right-edge clipping.
    write_spr(2, 600, 0, 12'h00F, 1'b0);
    pix(639, 0, 1'b1, 12'h123, 1'b0, 0, "t4_not_yet");     exp_coll(5'b00011, "t3_coll_hold");
    idle(3);
    frame_pulse();                    exp_coll(5'b00000, "t4_coll_clear");
    pix(639, 0, 1'b1, 12'h00F, 1'b1, 2, "t4_edge");        exp_addr(2, 39, "t4_addr39");
    pix(0, 0, 1'b1, 12'h123, 1'b0, 0, "t4_nowrap");        exp_addr(2, 0, "t4_addr_nowrap");
    pix(639, 127, 1'b1, 12'h00F, 1'b1, 2, "t4_edge_bot");  exp_addr(2, 16295, "t4_addr_bot");
    pix(639, 128, 1'b1, 12'h123, 1'b0, 0, "t4_below");

    // Write with frame_start forwarded; out-of-range index ignored; highest index works.
    idle(3);
    write_spr(3, 10, 10, 12'hFFF, 1'b1);
    pix(10, 10, 1'b1, 12'hFFF, 1'b1, 3, "t5_fwd");
    idle(3);
    write_spr(5, 20, 400, 12'hABC, 1'b0);
    frame_pulse();
    pix(20, 400, 1'b1, 12'h123, 1'b0, 0, "t5_idx5_ignored");
    idle(3);
    write_spr(4, 20, 400, 12'hABC, 1'b1);
    pix(20, 400, 1'b1, 12'hABC, 1'b1, 4, "t5_idx4");

    // Reset mid-line with collisions accumulated and a pixel in flight.
    pix(300, 200, 1'b1, 12'h0F0, 1'b1, 0, "t6_overlap");
    idle(3);
    drive_px(300, 200, 1'b1);
    @(negedge clk);
    #2 arst_n = 1'b0;
    exp_zero("t6_reset_flush");
    @(negedge clk);
    @(negedge clk);
    #1 arst_n = 1'b1;
    frame_pulse();                    exp_coll(5'b00000, "t6_coll_after_reset");
    pix(300, 200, 1'b1, 12'h123, 1'b0, 0, "t6_sprites_cleared");

    idle(LAT + 5);
    if (q.size() != 0) begin
      n_vec += q.size();
      n_bad += q.size();
      $display("FAIL drain: got %0d expectations still pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
